// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS countdown controller.
// Latency: n/a (declarations only). Backpressure: n/a.
package timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_ALARM = 3'd4
    } state_t;

    localparam logic [3:0] SEC_ONES_MAX = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] MIN_ONES_MAX = 4'd9;
    localparam logic [3:0] MIN_TENS_MAX = 4'd9;

    localparam logic [1:0] CUR_SEC_ONES = 2'd0;
    localparam logic [1:0] CUR_SEC_TENS = 2'd1;
    localparam logic [1:0] CUR_MIN_ONES = 2'd2;
    localparam logic [1:0] CUR_MIN_TENS = 2'd3;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register counting 0..MAX with wrap; borrow flags a decrement from 0.
// Latency: value updates one clock after a strobe. Backpressure: none, strobes always accepted.
// Priority: reset/clr > load > inc > dec.
module bcd_digit #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dec,
    input  logic       inc,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] value,
    output logic       borrow
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            value <= 4'd0;
        end else if (load) begin
            value <= load_val;
        end else if (inc) begin
            value <= (value >= MAX) ? 4'd0 : value + 4'd1;
        end else if (dec) begin
            value <= (value == 4'd0) ? MAX : value - 4'd1;
        end
    end

    assign borrow = dec && (value == 4'd0);

endmodule

// File: rtl/countdown_ctrl.sv
// MM:SS countdown front-panel controller (IDLE/SET/RUN/PAUSE/ALARM); COUNTDOWN_RELOAD_EN adds a preset reload.
// Latency: button/tick effects visible one clock after the strobe. Backpressure: none, strobes
// are single-cycle; lower-priority or illegal buttons in the same cycle are dropped.
module countdown_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned ALARM_TICKS = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        btn_start,
    input  logic        btn_stop,
    input  logic        btn_set,
    input  logic        btn_up,
    input  logic        btn_next,
    output logic [15:0] digits,
    output logic [1:0]  cursor,
    output logic [2:0]  state,
    output logic        alarm
);

    localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS - 1);

    state_t      state_q, state_d;
    logic [1:0]  cursor_q, cursor_d;
    logic [7:0]  alarm_cnt;
    logic [3:0]  dig_val [4];
    logic [3:0]  dig_inc;
    logic [2:0]  borrow_chain;
    logic        unused_top_borrow;
    logic        run_dec, up_ev, finish, clr_all, load_all;
    logic [15:0] preset_val;

    assign digits = {dig_val[3], dig_val[2], dig_val[1], dig_val[0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cursor_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        case (state_q)
            ST_IDLE: begin
                if (btn_start && (digits != 16'h0000)) begin
                    state_d = ST_RUN;
                end else if (btn_set) begin
                    state_d  = ST_SET;
                    cursor_d = CUR_MIN_TENS;
                end
            end
            ST_SET: begin
                if (btn_stop || btn_set) begin
                    state_d  = ST_IDLE;
                    cursor_d = 2'd0;
                end else if (btn_next) begin
                    if (cursor_q == CUR_SEC_ONES) state_d = ST_IDLE;
                    else                          cursor_d = cursor_q - 2'd1;
                end
            end
            ST_RUN: begin
                if (btn_stop)                          state_d = ST_PAUSE;
                else if (tick && digits == 16'h0001)   state_d = ST_ALARM;
            end
            ST_PAUSE: begin
                if (btn_stop)       state_d = ST_IDLE;
                else if (btn_start) state_d = ST_RUN;
            end
            ST_ALARM: begin
                if (btn_stop || (tick && alarm_cnt == ALARM_LAST)) state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                cursor_d = 2'd0;
            end
        endcase
    end

    // Digit-chain controls; a tick coinciding with btn_stop never decrements.
    always_comb begin
        run_dec = (state_q == ST_RUN) && tick && !btn_stop;
        up_ev   = (state_q == ST_SET) && btn_up && !btn_stop && !btn_set && !btn_next;
        finish  = ((state_q == ST_PAUSE) || (state_q == ST_ALARM)) && (state_d == ST_IDLE);
        for (int i = 0; i < 4; i++) begin
            dig_inc[i] = up_ev && (cursor_q == 2'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset || state_q != ST_ALARM) alarm_cnt <= 8'd0;
        else if (tick)                    alarm_cnt <= alarm_cnt + 8'd1;
    end

`ifdef COUNTDOWN_RELOAD_EN
    logic [15:0] preset_q;
    always_ff @(posedge clk) begin
        if (reset)                                      preset_q <= 16'h0000;
        else if (state_q == ST_SET && state_d != ST_SET) preset_q <= digits;
    end
    assign preset_val = preset_q;
    assign load_all   = finish;
    assign clr_all    = 1'b0;
`else
    assign preset_val = 16'h0000;
    assign load_all   = 1'b0;
    assign clr_all    = finish;
`endif

    bcd_digit #(.MAX(SEC_ONES_MAX)) u_sec_ones (
        .clk(clk), .reset(reset), .dec(run_dec), .inc(dig_inc[0]), .clr(clr_all),
        .load(load_all), .load_val(preset_val[3:0]), .value(dig_val[0]), .borrow(borrow_chain[0])
    );
    bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .reset(reset), .dec(borrow_chain[0]), .inc(dig_inc[1]), .clr(clr_all),
        .load(load_all), .load_val(preset_val[7:4]), .value(dig_val[1]), .borrow(borrow_chain[1])
    );
    bcd_digit #(.MAX(MIN_ONES_MAX)) u_min_ones (
        .clk(clk), .reset(reset), .dec(borrow_chain[1]), .inc(dig_inc[2]), .clr(clr_all),
        .load(load_all), .load_val(preset_val[11:8]), .value(dig_val[2]), .borrow(borrow_chain[2])
    );
    // RUN leaves at 00:01, so the top digit never borrows.
    bcd_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk(clk), .reset(reset), .dec(borrow_chain[2]), .inc(dig_inc[3]), .clr(clr_all),
        .load(load_all), .load_val(preset_val[15:12]), .value(dig_val[3]), .borrow(unused_top_borrow)
    );

    assign cursor = cursor_q;
    assign state  = state_q;
    assign alarm  = (state_q == ST_ALARM);

endmodule

// File: tb/tb_countdown_ctrl.sv
// Scoreboard bench for countdown_ctrl (ALARM_TICKS=3); expectations queued at drive, checked after the edge.
module tb_countdown_ctrl;

    localparam logic [4:0] B_NONE  = 5'b00000;
    localparam logic [4:0] B_UP    = 5'b00001;
    localparam logic [4:0] B_NEXT  = 5'b00010;
    localparam logic [4:0] B_SET   = 5'b00100;
    localparam logic [4:0] B_START = 5'b01000;
    localparam logic [4:0] B_STOP  = 5'b10000;
    localparam logic [2:0] S_IDLE = 3'd0, S_SET = 3'd1, S_RUN = 3'd2, S_PAUSE = 3'd3, S_ALARM = 3'd4;

    logic        clk = 1'b0;
    logic        reset = 1'b0, tick = 1'b0;
    logic        btn_start = 1'b0, btn_stop = 1'b0, btn_set = 1'b0, btn_up = 1'b0, btn_next = 1'b0;
    logic [15:0] digits;
    logic [1:0]  cursor;
    logic [2:0]  state;
    logic        alarm;

    countdown_ctrl #(.ALARM_TICKS(3)) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .btn_start(btn_start), .btn_stop(btn_stop), .btn_set(btn_set),
        .btn_up(btn_up), .btn_next(btn_next),
        .digits(digits), .cursor(cursor), .state(state), .alarm(alarm)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [21:0] exp_q [$];
    string       tag_q [$];
    logic [15:0] ed = 16'h0000;
    logic [15:0] ep = 16'h0000;

    task automatic check_vec(input string tag, input logic [21:0] got, input logic [21:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got state=%0d digits=%h cursor=%0d alarm=%b, want state=%0d digits=%h cursor=%0d alarm=%b",
                     tag, got[21:19], got[18:3], got[2:1], got[0],
                     want[21:19], want[18:3], want[2:1], want[0]);
        end
    endtask

    task automatic step(input logic [4:0] b, input logic t, input logic [2:0] es,
                        input logic [1:0] ec, input string tag);
        logic [21:0] e;
        string       tg;
        exp_q.push_back({es, ed, ec, (es == S_ALARM)});
        tag_q.push_back(tag);
        @(negedge clk);
        {btn_stop, btn_start, btn_set, btn_next, btn_up} = b;
        tick = t;
        @(posedge clk);
        #1;
        {btn_stop, btn_start, btn_set, btn_next, btn_up} = B_NONE;
        tick = 1'b0;
        e  = exp_q.pop_front();
        tg = tag_q.pop_front();
        check_vec(tg, {state, digits, cursor, alarm}, e);
    endtask

    task automatic do_reset();
        ed = 16'h0000;
        ep = 16'h0000;
        exp_q.push_back({S_IDLE, 16'h0000, 2'd0, 1'b0});
        tag_q.push_back("reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_vec(tag_q.pop_front(), {state, digits, cursor, alarm}, exp_q.pop_front());
    endtask

    function automatic logic [3:0] lim(input int pos);
        return (pos == 1) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [15:0] to_bcd(input int s);
        int m = s / 60;
        int x = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic logic [15:0] after_exit();
`ifdef COUNTDOWN_RELOAD_EN
        return ep;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic bump(input int pos);
        logic [3:0] d;
        d = ed[pos*4 +: 4];
        ed[pos*4 +: 4] = (d == lim(pos)) ? 4'd0 : d + 4'd1;
    endtask

    task automatic set_time(input int n3, input int n2, input int n1, input int n0);
        int n [4];
        n[3] = n3; n[2] = n2; n[1] = n1; n[0] = n0;
        step(B_SET, 1'b0, S_SET, 2'd3, "enter_set");
        for (int p = 3; p >= 0; p--) begin
            for (int k = 0; k < n[p]; k++) begin
                bump(p);
                step(B_UP, 1'b0, S_SET, 2'(p), "set_up");
            end
            if (p == 0) begin
                ep = ed;
                step(B_NEXT, 1'b0, S_IDLE, 2'd0, "set_exit");
            end else begin
                step(B_NEXT, 1'b0, S_SET, 2'(p - 1), "set_next");
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        step(B_START, 1'b0, S_IDLE, 2'd0, "idle_start_zero");

        // digit wrap at cursor 2 (limit 9) and cursor 1 (limit 5)
        step(B_SET,  1'b0, S_SET, 2'd3, "enter_set");
        step(B_NEXT, 1'b0, S_SET, 2'd2, "cur2");
        for (int k = 0; k < 10; k++) begin
            bump(2);
            step(B_UP, 1'b0, S_SET, 2'd2, "min_ones_up");
        end
        step(B_NEXT, 1'b0, S_SET, 2'd1, "cur1");
        for (int k = 0; k < 6; k++) begin
            bump(1);
            step(B_UP, 1'b0, S_SET, 2'd1, "sec_tens_up");
        end
        ep = ed;
        step(B_SET, 1'b0, S_IDLE, 2'd0, "set_leave");

        // priority and ignored inputs
        step(B_STOP | B_SET, 1'b0, S_SET, 2'd3, "idle_stop_set");
        step(B_NONE, 1'b1, S_SET, 2'd3, "set_tick_ignored");
        ep = ed;
        step(B_STOP | B_UP, 1'b0, S_IDLE, 2'd0, "set_stop_beats_up");

        // 00:01 into ALARM, then acknowledged by btn_stop
        set_time(0, 0, 0, 1);
        step(B_START, 1'b0, S_RUN, 2'd0, "start_0001");
        ed = 16'h0000;
        step(B_NONE, 1'b1, S_ALARM, 2'd0, "run_to_alarm");
        step(B_NONE, 1'b1, S_ALARM, 2'd0, "alarm_tick1");
        ed = after_exit();
        step(B_STOP, 1'b0, S_IDLE, 2'd0, "alarm_stop");

        // full 01:05 countdown and alarm timeout
        do_reset();
        set_time(0, 1, 0, 5);
        step(B_START, 1'b0, S_RUN, 2'd0, "start_0105");
        for (int k = 1; k <= 65; k++) begin
            ed = to_bcd(65 - k);
            step(B_NONE, 1'b1, (k == 65) ? S_ALARM : S_RUN, 2'd0, "run_tick");
            if (k == 30) step(B_NONE, 1'b0, S_RUN, 2'd0, "run_hold");
        end
        step(B_NONE, 1'b1, S_ALARM, 2'd0, "alarm_t1");
        step(B_NONE, 1'b0, S_ALARM, 2'd0, "alarm_hold");
        step(B_NONE, 1'b1, S_ALARM, 2'd0, "alarm_t2");
        ed = after_exit();
        step(B_NONE, 1'b1, S_IDLE, 2'd0, "alarm_timeout");

        // pause interactions at 00:10
        do_reset();
        set_time(0, 0, 1, 0);
        step(B_START, 1'b0, S_RUN, 2'd0, "start_0010");
        step(B_STOP, 1'b1, S_PAUSE, 2'd0, "run_tick_stop");
        step(B_NONE, 1'b1, S_PAUSE, 2'd0, "pause_tick_ignored");
        step(B_START, 1'b1, S_RUN, 2'd0, "pause_start_tick");
        ed = 16'h0009;
        step(B_NONE, 1'b1, S_RUN, 2'd0, "first_dec");
        step(B_STOP, 1'b0, S_PAUSE, 2'd0, "pause");
        ed = after_exit();
        step(B_STOP, 1'b0, S_IDLE, 2'd0, "pause_stop");

        // reset in the middle of a run at 12:34
        do_reset();
        set_time(1, 2, 3, 4);
        step(B_START, 1'b0, S_RUN, 2'd0, "start_1234");
        ed = 16'h1233;
        step(B_NONE, 1'b1, S_RUN, 2'd0, "tick_1234");
        do_reset();
        step(B_START, 1'b0, S_IDLE, 2'd0, "start_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/countdown_ctrl.md
# countdown_ctrl

Four-digit MM:SS countdown controller. Sequences a chain of BCD digit counters through set, run, pause and alarm phases. Accepts pre-debounced single-cycle button pulses and a 1 Hz tick strobe. Drives the display digits and the alarm output of the timer front panel.

## Interface

- ALARM_TICKS, default 10: number of ticks the ALARM state lasts before it returns to IDLE automatically (range 1–255).
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- tick  in  1  one-cycle 1 Hz strobe.
- btn_start  in  1  one-cycle pulse: start or resume.
- btn_stop  in  1  one-cycle pulse: pause, abort or acknowledge.
- btn_set  in  1  one-cycle pulse: enter or leave set mode.
- btn_up  in  1  one-cycle pulse: increment the selected digit.
- btn_next  in  1  one-cycle pulse: advance the set cursor.
- digits  out  16  BCD digits {min_tens, min_ones, sec_tens, sec_ones}, registered.
- cursor  out  2  selected digit in SET (3 = min_tens … 0 = sec_ones); 0 outside SET.
- state  out  3  current FSM state encoding.
- alarm  out  1  high while in ALARM.

## Operation

- **States:** IDLE, SET, RUN, PAUSE, ALARM. Reset gives state=IDLE, digits=0, cursor=0, alarm=0.
- **Button priority** within a cycle: btn_stop > btn_start > btn_set > btn_next > btn_up. Only the highest-priority pulse that is legal in the current state acts. The rest are dropped.
- **IDLE:**
  - btn_set → SET with cursor=3.
  - btn_start → RUN if digits≠0. If digits=0, btn_start is ignored.
- **SET:**
  - btn_up increments the digit at the cursor modulo its limit, wrapping to 0. Limits: sec_ones 9, sec_tens 5, min_ones 9, min_tens 9.
  - btn_next decrements the cursor. btn_next at cursor=0 → IDLE.
  - btn_set → IDLE.
  - btn_stop → IDLE, digits unchanged.
  - tick is ignored.
- **RUN:**
  - On tick, decrement MM:SS by one second using a borrow chain. A digit at 0 reloads to its limit and borrows from the next higher digit.
  - If the decrement leaves digits=0, go to ALARM.
  - btn_stop → PAUSE.
- **PAUSE:**
  - tick is ignored.
  - btn_start → RUN.
  - btn_stop → IDLE, with digits handled per Configuration.
- **ALARM:**
  - alarm=1. An internal tick counter is cleared on entry.
  - After ALARM_TICKS ticks, or on btn_stop, go to IDLE, with digits handled per Configuration.
- **Arithmetic:** each digit is 4-bit BCD and never leaves its range. Out-of-range values cannot be entered.

## Timing

- All outputs are registered. The effect of a button or tick is visible on the cycle after the strobe.
- The final decrement to 0000 and alarm=1 appear on the same clock edge.
- **Simultaneous events:**
  - RUN + tick + btn_stop: PAUSE is entered and the decrement is suppressed.
  - PAUSE + tick + btn_start: RUN is entered and the first decrement happens on the next tick.
  - RUN + tick at digits=0001: ALARM is entered directly.
- ALARM with ALARM_TICKS=10 ends on the edge after the 10th tick.
- Reset asserted in any state returns to the reset values on the next edge. Any set or run in progress is abandoned.

## Configuration

- **COUNTDOWN_RELOAD_EN defined:**
  - A 16-bit preset register captures digits on every exit from SET.
  - Leaving PAUSE or ALARM via btn_stop or ALARM timeout reloads digits from the preset.
  - Reset clears the preset to 0.
- **COUNTDOWN_RELOAD_EN undefined:**
  - No preset register exists.
  - Those same exits clear digits to 0.

## Structure

- **timer_pkg** holds:
  - the state enum (IDLE=0, SET=1, RUN=2, PAUSE=3, ALARM=4);
  - digit limit constants (SEC_ONES_MAX=9, SEC_TENS_MAX=5, MIN_ONES_MAX=9, MIN_TENS_MAX=9);
  - the cursor index constants.
- **bcd_digit sub-module**, instantiated four times. Each instance has:
  - parameter MAX;
  - inputs dec, inc, clr, load, load_val;
  - outputs value and borrow.
  - borrow = dec & (value==0).
  - The controller chains each borrow into the next higher digit's dec.

## Test plan

- Set 01:05 via set/up/next, start, apply 65 ticks → digits step down through 01:00, 00:59, …, 00:00. alarm=1 on the 65th decrement edge.
- RUN at 00:10, pulse tick and btn_stop in the same cycle → state=PAUSE, digits stay 00:10. btn_start then one tick → 00:09.
- IDLE at 00:00, btn_start → state stays IDLE.
- SET cursor=2, 10 btn_up pulses → min_ones 1…9 then wraps to 0. cursor=1: 6 pulses → sec_tens wraps to 0.
- ALARM with ALARM_TICKS=3, apply 3 ticks → IDLE. digits=preset with COUNTDOWN_RELOAD_EN defined, otherwise 0000.
- RUN at 12:34, assert reset for one cycle → next edge gives state=IDLE, digits=0000, alarm=0.
